// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared definitions for the instruction/data memory arbiter:
//                bus widths, FSM state encoding, grant identifiers and the
//                latched command record.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   // Grant identifiers
   localparam logic GNT_IF = 1'b0;
   localparam logic GNT_DM = 1'b1;

   // Command captured at grant time and replayed onto the memory bus
   typedef struct packed {
      logic              gnt_id;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } cmd_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Bundle of the fetch port, data port and shared memory port.
//                master : requesters plus memory (drive requests, mem_rdata)
//                slave  : the arbiter (drives ready/rdata and memory command)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;
   import mem_arb_pkg::*;

   // Instruction fetch port
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ready;

   // Data port
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_ready;

   // Shared single-port memory
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_read;
   logic              mem_write;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_rdata, if_ready, dm_rdata, dm_ready,
             mem_addr, mem_read, mem_write, mem_wdata
   );

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_rdata, if_ready, dm_rdata, dm_ready,
             mem_addr, mem_read, mem_write, mem_wdata
   );

endinterface
`default_nettype wire

// File: rtl/mem_arb_prio.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_prio
//  Description : Fetch/data priority select with starvation guard. Data wins
//                by default; once STARVE_MAX data grants have been made while
//                a fetch waits, the fetch wins the next arbitration.
//  Ports       : clk, reset     - clock, synchronous active-high reset
//                if_req, dm_req - pending requests
//                arb_en         - arbiter is in IDLE (grant decision point)
//                grant_valid    - some request is pending
//                grant_id       - GNT_IF or GNT_DM
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_prio
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic if_req,
   input  logic dm_req,
   input  logic arb_en,
   output logic grant_valid,
   output logic grant_id
);

   localparam int            SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   logic [SW-1:0] starve_cnt;
   logic          fetch_wins;

   always_comb begin
      fetch_wins  = if_req && (!dm_req || (starve_cnt == STARVE_LIM));
      grant_valid = if_req || dm_req;
      grant_id    = fetch_wins ? GNT_IF : GNT_DM;
   end

   // Only IDLE cycles matter: every pending-request IDLE cycle is a grant.
   // A losing fetch implies a data grant made while a fetch waits.
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (arb_en) begin
         if (!if_req || fetch_wins) begin
            starve_cnt <= '0;
         end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one single-port memory between an instruction fetch
//                port and a data port. One access in flight at a time:
//                IDLE (arbitrate) -> BUSY (MEM_LAT cycles of strobe) ->
//                RESP (one-cycle ready pulse) -> IDLE.
//  Ports       : clk   - clock
//                reset - synchronous active-high reset
//                bus   - mem_arbiter_if.slave (fetch, data, memory ports)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MEM_LAT    = 2,   // legal 1..15
   parameter int STARVE_MAX = 3
) (
   input  logic          clk,
   input  logic          reset,
   mem_arbiter_if.slave  bus
);

   localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

   logic [1:0]        state;
   logic [3:0]        lat_cnt;
   cmd_t              cmd;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] dm_rdata_q;

   logic arb_en;
   logic grant_valid;
   logic grant_id;

   assign arb_en = (state == ST_IDLE);

   mem_arb_prio #(
      .STARVE_MAX (STARVE_MAX)
   ) u_prio (
      .clk         (clk),
      .reset       (reset),
      .if_req      (bus.if_req),
      .dm_req      (bus.dm_req),
      .arb_en      (arb_en),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         lat_cnt    <= '0;
         cmd        <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant_valid) begin
                  cmd.gnt_id <= grant_id;
                  if (grant_id == GNT_IF) begin
                     // Fetches leave the write-data register untouched so
                     // mem_wdata keeps its last value.
                     cmd.we   <= 1'b0;
                     cmd.addr <= bus.if_addr;
                  end else begin
                     cmd.we    <= bus.dm_we;
                     cmd.addr  <= bus.dm_addr;
                     cmd.wdata <= bus.dm_wdata;
                  end
                  lat_cnt <= LAT_LOAD;
                  state   <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (lat_cnt == 4'd0) begin
                  // Last cycle of the access: memory data is valid now.
                  if (!cmd.we) begin
                     if (cmd.gnt_id == GNT_IF) begin
                        if_rdata_q <= bus.mem_rdata;
                     end else begin
                        dm_rdata_q <= bus.mem_rdata;
                     end
                  end
                  state <= ST_RESP;
               end else begin
                  lat_cnt <= lat_cnt - 4'd1;
               end
            end
            ST_RESP: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Strobes and ready pulses decode straight from the state register, so a
   // reset edge removes them in the very next cycle.
   assign bus.mem_read  = (state == ST_BUSY) && !cmd.we;
   assign bus.mem_write = (state == ST_BUSY) &&  cmd.we;
   assign bus.mem_addr  = cmd.addr;
   assign bus.mem_wdata = cmd.wdata;

   assign bus.if_ready  = (state == ST_RESP) && (cmd.gnt_id == GNT_IF);
   assign bus.dm_ready  = (state == ST_RESP) && (cmd.gnt_id == GNT_DM);
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_rdata  = dm_rdata_q;

endmodule
`default_nettype wire
